// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, result-broadcast and issue signals of the ALU reservation station.
interface rs_alu_if #(
    parameter int NICK_W = 4,
    parameter int OP_W   = 6
);
    logic              rdy;
    logic              i_clr;
    logic              iDP_en;
    logic [31:0]       iDP_pc;
    logic [31:0]       iDP_imm;
    logic [OP_W-1:0]   iDP_op;
    logic [NICK_W-1:0] iDP_rd_nick;
    logic              iDP_rs1_rdy;
    logic              iDP_rs2_rdy;
    logic [31:0]       iDP_rs1_dt;
    logic [31:0]       iDP_rs2_dt;
    logic [NICK_W-1:0] iDP_rs1_nick;
    logic [NICK_W-1:0] iDP_rs2_nick;
    logic              oDP_full;
    logic              iEX_en;
    logic [NICK_W-1:0] iEX_nick;
    logic [31:0]       iEX_dt;
    logic              iSLB_en;
    logic [NICK_W-1:0] iSLB_nick;
    logic [31:0]       iSLB_dt;
    logic              oEX_en;
    logic [31:0]       oEX_pc;
    logic [31:0]       oEX_imm;
    logic [31:0]       oEX_rs1_dt;
    logic [31:0]       oEX_rs2_dt;
    logic [OP_W-1:0]   oEX_op;
    logic [NICK_W-1:0] oEX_rd_nick;

    modport master (
        output rdy, i_clr, iDP_en, iDP_pc, iDP_imm, iDP_op, iDP_rd_nick,
               iDP_rs1_rdy, iDP_rs2_rdy, iDP_rs1_dt, iDP_rs2_dt, iDP_rs1_nick, iDP_rs2_nick,
               iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
        input  oDP_full, oEX_en, oEX_pc, oEX_imm, oEX_rs1_dt, oEX_rs2_dt, oEX_op, oEX_rd_nick
    );
    modport slave (
        input  rdy, i_clr, iDP_en, iDP_pc, iDP_imm, iDP_op, iDP_rd_nick,
               iDP_rs1_rdy, iDP_rs2_rdy, iDP_rs1_dt, iDP_rs2_dt, iDP_rs1_nick, iDP_rs2_nick,
               iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt,
        output oDP_full, oEX_en, oEX_pc, oEX_imm, oEX_rs1_dt, oEX_rs2_dt, oEX_op, oEX_rd_nick
    );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station with operand wake-up and single issue per cycle.
// Define RS_AGE_SEL_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_alu #(
    parameter int RS_SIZE = 8,
    parameter int NICK_W  = 4,
    parameter int OP_W    = 6
) (
    input logic     clk,
    input logic     rst,
    rs_alu_if.slave bus
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] valid, r1, r2, can_issue;
    logic [31:0]        pc [RS_SIZE];
    logic [31:0]        imm [RS_SIZE];
    logic [31:0]        d1 [RS_SIZE];
    logic [31:0]        d2 [RS_SIZE];
    logic [OP_W-1:0]    op [RS_SIZE];
    logic [NICK_W-1:0]  rd [RS_SIZE];
    logic [NICK_W-1:0]  n1 [RS_SIZE];
    logic [NICK_W-1:0]  n2 [RS_SIZE];
    logic [IW-1:0]      free_idx, sel_idx;
    logic               sel_ok, alloc;
    logic               f1_ex, f1_slb, f2_ex, f2_slb;

    assign bus.oDP_full = &valid;
    assign can_issue    = valid & r1 & r2;
    assign alloc        = bus.iDP_en && !bus.oDP_full;
    assign f1_ex        = bus.iEX_en && bus.iEX_nick == bus.iDP_rs1_nick;
    assign f1_slb       = bus.iSLB_en && bus.iSLB_nick == bus.iDP_rs1_nick;
    assign f2_ex        = bus.iEX_en && bus.iEX_nick == bus.iDP_rs2_nick;
    assign f2_slb       = bus.iSLB_en && bus.iSLB_nick == bus.iDP_rs2_nick;

    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!valid[i]) free_idx = i[IW-1:0];
    end

`ifdef RS_AGE_SEL_EN
    // older[i][j] set: entry j was allocated before entry i
    logic [RS_SIZE-1:0] older [RS_SIZE];

    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < RS_SIZE; i++)
            if (can_issue[i] && !(|(can_issue & older[i]))) begin
                sel_ok  = 1'b1;
                sel_idx = i[IW-1:0];
            end
    end

    always_ff @(posedge clk)
        if (!rst && bus.rdy && !bus.i_clr && alloc) begin
            for (int i = 0; i < RS_SIZE; i++) older[i][free_idx] <= 1'b0;
            older[free_idx] <= ~(RS_SIZE'(1) << free_idx);
        end
`else
    always_comb begin
        sel_ok  = |can_issue;
        sel_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (can_issue[i]) sel_idx = i[IW-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid          <= '0;
            r1             <= '0;
            r2             <= '0;
            bus.oEX_en      <= 1'b0;
            bus.oEX_pc      <= '0;
            bus.oEX_imm     <= '0;
            bus.oEX_rs1_dt  <= '0;
            bus.oEX_rs2_dt  <= '0;
            bus.oEX_op      <= '0;
            bus.oEX_rd_nick <= '0;
        end else if (!bus.rdy) begin
            bus.oEX_en <= 1'b0;
        end else if (bus.i_clr) begin
            valid      <= '0;
            bus.oEX_en <= 1'b0;
        end else begin
            // iEX wins over iSLB when both carry the awaited tag
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i] && !r1[i] && bus.iEX_en && n1[i] == bus.iEX_nick) begin
                    d1[i] <= bus.iEX_dt;
                    r1[i] <= 1'b1;
                end else if (valid[i] && !r1[i] && bus.iSLB_en && n1[i] == bus.iSLB_nick) begin
                    d1[i] <= bus.iSLB_dt;
                    r1[i] <= 1'b1;
                end
                if (valid[i] && !r2[i] && bus.iEX_en && n2[i] == bus.iEX_nick) begin
                    d2[i] <= bus.iEX_dt;
                    r2[i] <= 1'b1;
                end else if (valid[i] && !r2[i] && bus.iSLB_en && n2[i] == bus.iSLB_nick) begin
                    d2[i] <= bus.iSLB_dt;
                    r2[i] <= 1'b1;
                end
            end
            bus.oEX_en <= sel_ok;
            if (sel_ok) begin
                valid[sel_idx]  <= 1'b0;
                bus.oEX_pc      <= pc[sel_idx];
                bus.oEX_imm     <= imm[sel_idx];
                bus.oEX_rs1_dt  <= d1[sel_idx];
                bus.oEX_rs2_dt  <= d2[sel_idx];
                bus.oEX_op      <= op[sel_idx];
                bus.oEX_rd_nick <= rd[sel_idx];
            end
            if (alloc) begin
                valid[free_idx] <= 1'b1;
                pc[free_idx]    <= bus.iDP_pc;
                imm[free_idx]   <= bus.iDP_imm;
                op[free_idx]    <= bus.iDP_op;
                rd[free_idx]    <= bus.iDP_rd_nick;
                n1[free_idx]    <= bus.iDP_rs1_nick;
                n2[free_idx]    <= bus.iDP_rs2_nick;
                r1[free_idx]    <= bus.iDP_rs1_rdy | f1_ex | f1_slb;
                r2[free_idx]    <= bus.iDP_rs2_rdy | f2_ex | f2_slb;
                d1[free_idx]    <= bus.iDP_rs1_rdy ? bus.iDP_rs1_dt : f1_ex ? bus.iEX_dt :
                                   f1_slb ? bus.iSLB_dt : bus.iDP_rs1_dt;
                d2[free_idx]    <= bus.iDP_rs2_rdy ? bus.iDP_rs2_dt : f2_ex ? bus.iEX_dt :
                                   f2_slb ? bus.iSLB_dt : bus.iDP_rs2_dt;
            end
        end
    end
endmodule
